// File: rtl/pixel_write_sink_pkg.sv
// Shared constants, the pixel record and address helpers for the pixel write sink.
// Contents:
//   SCREEN_W/SCREEN_H  visible framebuffer geometry
//   FB_ADDR_W          framebuffer address width
//   COLOUR_W           bits of colour per pixel
//   FB_LAST_ADDR       linear address of the bottom-right pixel
//   pixel_t            {x, y, colour} record held in the input FIFO
package pixel_write_sink_pkg;

    localparam int unsigned SCREEN_W   = 320;
    localparam int unsigned SCREEN_H   = 240;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned FB_ADDR_W  = 17;
    localparam int unsigned COLOUR_W   = 3;
    localparam int unsigned X_W        = 9;
    localparam int unsigned Y_W        = 8;
    localparam int unsigned PIXEL_W    = X_W + Y_W + COLOUR_W;

    localparam logic [FB_ADDR_W-1:0] FB_LAST_ADDR = 17'd76799;
    localparam logic [X_W-1:0]       X_LIMIT      = X_W'(SCREEN_W);
    localparam logic [Y_W-1:0]       Y_LIMIT      = Y_W'(SCREEN_H);

    typedef struct packed {
        logic [X_W-1:0]      x;
        logic [Y_W-1:0]      y;
        logic [COLOUR_W-1:0] colour;
    } pixel_t;

    function automatic logic pixel_in_range(input pixel_t p);
        return (p.x < X_LIMIT) && (p.y < Y_LIMIT);
    endfunction

    // y*320 + x as (y<<8) + (y<<6) + x; every term is zero-extended to 17 bits.
    function automatic logic [FB_ADDR_W-1:0] pixel_addr(input pixel_t p);
        return {1'b0, p.y, 8'b0} + {3'b0, p.y, 6'b0} + {8'b0, p.x};
    endfunction

endpackage

// File: rtl/pixel_write_sink_fifo.sv
// Synchronous FIFO buffering incoming pixels ahead of the framebuffer output stage.
// Ports:
//   CLOCK_50  clock (rising edge)
//   reset     synchronous active-low reset; empties the FIFO
//   push      write wdata this edge (ignored when full)
//   wdata     entry to store
//   pop       remove the head entry this edge (ignored when empty)
//   rdata     head entry (valid when not empty)
//   full      count == Depth
//   empty     count == 0
//   count     number of stored entries, 0..Depth
module pixel_fifo #(
    parameter int unsigned Width = 20,
    parameter int unsigned Depth = 4,
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1,
    localparam int unsigned CntW = $clog2(Depth + 1)
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             push,
    input  logic [Width-1:0] wdata,
    input  logic             pop,
    output logic [Width-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CntW-1:0]  count
);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             push_ok;
    logic             pop_ok;

    always_comb begin
        full    = (count_q == CntW'(Depth));
        empty   = (count_q == '0);
        push_ok = push && !full;
        pop_ok  = pop && !empty;
        rdata   = mem_q[rd_ptr_q];
        count   = count_q;
    end

    // Pointers wrap naturally because Depth is a power of two.
    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CntW'(push_ok) - CntW'(pop_ok);
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/pixel_write_sink.sv
// Pixel write sink: accepts (x, y, colour) plots, buffers them, range-checks each one,
// converts it to a linear 320x240 framebuffer address and issues one registered write
// per framebuffer handshake. Counts written and dropped pixels and pulses frame_done
// after the last screen address is written.
// Ports:
//   CLOCK_50, reset   clock and synchronous active-low reset
//   clear             zero pix_count/drop_count (FIFO and output stage untouched)
//   plot, x, y, colour, in_ready   drawer-side handshake and pixel
//   fb_we, fb_addr, fb_data, fb_ready   framebuffer write port
//   pix_count, drop_count, frame_done   status towards the game controller
module pixel_write_sink
    import pixel_write_sink_pkg::*;
(
    input  logic                 CLOCK_50,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 plot,
    input  logic [X_W-1:0]       x,
    input  logic [Y_W-1:0]       y,
    input  logic [COLOUR_W-1:0]  colour,
    output logic                 in_ready,
    output logic                 fb_we,
    output logic [FB_ADDR_W-1:0] fb_addr,
    output logic [COLOUR_W-1:0]  fb_data,
    input  logic                 fb_ready,
    output logic [16:0]          pix_count,
    output logic [7:0]           drop_count,
    output logic                 frame_done
);

    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

    pixel_t          wr_pixel;
    pixel_t          head;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CntW-1:0] fifo_count;
    logic            push;
    logic            pop;
    logic            stage_free;
    logic            write_done;
    logic            head_ok;

    always_comb begin
        wr_pixel   = '{x: x, y: y, colour: colour};
        // in_ready depends only on registered FIFO state, so a same-edge pop never frees a slot.
        in_ready   = (fifo_count != CntW'(FIFO_DEPTH));
        push       = plot && !fifo_full;
        stage_free = !fb_we || fb_ready;
        pop        = !fifo_empty && stage_free;
        write_done = fb_we && fb_ready;
        head_ok    = pixel_in_range(head);
    end

    pixel_fifo #(
        .Width (PIXEL_W),
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .push     (push),
        .wdata    (wr_pixel),
        .pop      (pop),
        .rdata    (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            fb_we      <= 1'b0;
            fb_addr    <= '0;
            fb_data    <= '0;
            pix_count  <= '0;
            drop_count <= '0;
            frame_done <= 1'b0;
        end else begin
            // A free stage either takes an in-range head or goes idle.
            if (stage_free) begin
                fb_we <= pop && head_ok;
                if (pop && head_ok) begin
                    fb_addr <= pixel_addr(head);
                    fb_data <= head.colour;
                end
            end

            frame_done <= write_done && (fb_addr == FB_LAST_ADDR);

            if (clear) begin
                pix_count  <= '0;
                drop_count <= '0;
            end else begin
                if (write_done && (pix_count != '1)) pix_count <= pix_count + 1'b1;
                if (pop && !head_ok && (drop_count != '1)) drop_count <= drop_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pixel_write_sink.sv
// Self-checking bench for pixel_write_sink: a vector table of single pixels plus
// directed sequences for streaming, backpressure, clear and reset. A negedge monitor
// scoreboards every completed framebuffer write and models pix_count/frame_done.
module tb_pixel_write_sink;

    logic        CLOCK_50;
    logic        reset;
    logic        clear;
    logic        plot;
    logic [8:0]  x;
    logic [7:0]  y;
    logic [2:0]  colour;
    logic        in_ready;
    logic        fb_we;
    logic [16:0] fb_addr;
    logic [2:0]  fb_data;
    logic        fb_ready;
    logic [16:0] pix_count;
    logic [7:0]  drop_count;
    logic        frame_done;

    pixel_write_sink dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .clear      (clear),
        .plot       (plot),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .in_ready   (in_ready),
        .fb_we      (fb_we),
        .fb_addr    (fb_addr),
        .fb_data    (fb_data),
        .fb_ready   (fb_ready),
        .pix_count  (pix_count),
        .drop_count (drop_count),
        .frame_done (frame_done)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        int unsigned addr;
        int unsigned data;
    } wr_t;

    typedef struct {
        int unsigned x;
        int unsigned y;
        int unsigned c;
        bit          valid;
        int unsigned addr;
    } vec_t;

    int   errors = 0;
    int   checks = 0;
    wr_t  exp_q[$];
    bit   mon_en = 1'b0;
    int unsigned model_pix = 0;
    bit   exp_fd = 1'b0;
    int   frame_pulses = 0;
    int   stalls = 0;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    // Scoreboard: each write completing at the next edge must be the oldest expected one.
    always @(negedge CLOCK_50) begin
        wr_t e;
        bit  done;
        if (mon_en) begin
            check("pix_count_model", pix_count, model_pix);
            check("frame_done_model", frame_done, exp_fd);
            if (frame_done === 1'b1) frame_pulses++;
            if (!reset) begin
                model_pix = 0;
                exp_fd    = 1'b0;
            end else begin
                done   = (fb_we === 1'b1) && (fb_ready === 1'b1);
                exp_fd = 1'b0;
                if (done) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write: got addr %0d expected no write", fb_addr);
                    end else begin
                        e = exp_q.pop_front();
                        check("wr_addr", fb_addr, e.addr);
                        check("wr_data", fb_data, e.data);
                        exp_fd = (e.addr == 76799);
                    end
                end
                if (clear) model_pix = 0;
                else if (done) model_pix++;
            end
        end
    end

    // Offer one pixel and hold it until accepted; plot is left high for back-to-back use.
    task automatic send(input int unsigned px, input int unsigned py, input int unsigned pc,
                        input bit valid, input int unsigned addr);
        int n = 0;
        wr_t e;
        plot   = 1'b1;
        x      = px[8:0];
        y      = py[7:0];
        colour = pc[2:0];
        while (!in_ready && n < 200) begin
            step();
            n++;
            stalls++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got in_ready 0 expected 1 within 200 cycles");
        end
        step();
        if (valid) begin
            e.addr = addr;
            e.data = pc;
            exp_q.push_back(e);
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || fb_we) && n < 500) begin
            step();
            n++;
        end
        if (n >= 500) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
        repeat (3) step();
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
        step();
    endtask

    vec_t vecs[11];

    initial begin
        int unsigned exp_pix;
        int unsigned exp_drop;
        int          fp0;
        bit          cleared;

        vecs[0]  = '{0,   0,   1, 1'b1, 0};
        vecs[1]  = '{319, 0,   2, 1'b1, 319};
        vecs[2]  = '{0,   1,   3, 1'b1, 320};
        vecs[3]  = '{320, 0,   4, 1'b0, 0};
        vecs[4]  = '{100, 100, 6, 1'b1, 32100};
        vecs[5]  = '{0,   240, 7, 1'b0, 0};
        vecs[6]  = '{7,   3,   0, 1'b1, 967};
        vecs[7]  = '{511, 255, 5, 1'b0, 0};
        vecs[8]  = '{319, 239, 1, 1'b1, 76799};
        vecs[9]  = '{1,   239, 2, 1'b1, 76481};
        vecs[10] = '{318, 239, 3, 1'b1, 76798};

        reset = 1'b0; clear = 1'b0; plot = 1'b0;
        x = '0; y = '0; colour = '0; fb_ready = 1'b1;
        repeat (3) step();
        check("rst_in_ready", in_ready, 1);
        check("rst_fb_we", fb_we, 0);
        check("rst_fb_addr", fb_addr, 0);
        check("rst_fb_data", fb_data, 0);
        check("rst_pix_count", pix_count, 0);
        check("rst_drop_count", drop_count, 0);
        check("rst_frame_done", frame_done, 0);
        mon_en = 1'b1;
        reset  = 1'b1;
        step();

        // Single pixel: push edge N, pop N+1, write completes N+2.
        send(5, 2, 5, 1'b1, 645);
        plot = 1'b0;
        check("single_we_early", fb_we, 0);
        step();
        check("single_we", fb_we, 1);
        check("single_addr", fb_addr, 645);
        check("single_data", fb_data, 5);
        step();
        check("single_pix_count", pix_count, 1);
        check("single_we_idle", fb_we, 0);

        // Vector table, one pixel at a time.
        pulse_clear();
        exp_pix = 0; exp_drop = 0;
        fp0 = frame_pulses;
        for (int i = 0; i < 11; i++) begin
            send(vecs[i].x, vecs[i].y, vecs[i].c, vecs[i].valid, vecs[i].addr);
            plot = 1'b0;
            drain();
            if (vecs[i].valid) exp_pix++;
            else exp_drop++;
            check("vec_pix_count", pix_count, exp_pix);
            check("vec_drop_count", drop_count, exp_drop);
        end
        check("vec_frame_pulses", frame_pulses - fp0, 1);

        // Stream the bottom 20 rows back to back.
        pulse_clear();
        stalls = 0;
        fp0 = frame_pulses;
        for (int yy = 220; yy < 240; yy++)
            for (int xx = 0; xx < 320; xx++)
                send(xx, yy, (xx + yy) % 8, 1'b1, yy * 320 + xx);
        plot = 1'b0;
        drain();
        check("stream_stalls", stalls, 0);
        check("stream_pix_count", pix_count, 6400);
        check("stream_frame_pulses", frame_pulses - fp0, 1);

        // Backpressure: one pixel in the stage, four fill the FIFO.
        pulse_clear();
        fb_ready = 1'b0;
        stalls = 0;
        for (int i = 0; i < 5; i++) send(10 + i, 1, i, 1'b1, 320 + 10 + i);
        check("bp_stalls", stalls, 0);
        check("bp_in_ready_full", in_ready, 0);
        x = 9'd99; y = 8'd1; colour = 3'd7;
        for (int i = 0; i < 3; i++) begin
            check("bp_hold_we", fb_we, 1);
            check("bp_hold_addr", fb_addr, 330);
            check("bp_hold_data", fb_data, 0);
            check("bp_hold_ready", in_ready, 0);
            step();
        end
        plot = 1'b0;
        fb_ready = 1'b1;
        drain();
        check("bp_pix_count", pix_count, 5);

        // Clear on a completing-write edge at pix_count=100.
        pulse_clear();
        cleared = 1'b0;
        for (int i = 0; i < 200; i++) begin
            send(i, 10, i % 8, 1'b1, 3200 + i);
            if (clear) begin
                clear = 1'b0;
                check("clear_zero", pix_count, 0);
            end else if (!cleared && pix_count == 100) begin
                check("clear_edge_we", fb_we, 1);
                clear = 1'b1;
                cleared = 1'b1;
            end
        end
        plot = 1'b0;
        drain();
        check("clear_seen", cleared, 1);
        check("clear_pix_after", pix_count, 99);
        check("clear_drop", drop_count, 0);

        // Reset with three pixels queued and a stalled write.
        fb_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(50 + i, 7, 3, 1'b1, 2240 + 50 + i);
        plot = 1'b0;
        check("rq_we_before", fb_we, 1);
        reset = 1'b0;
        step();
        exp_q.delete();
        check("rq_we", fb_we, 0);
        check("rq_in_ready", in_ready, 1);
        check("rq_pix_count", pix_count, 0);
        check("rq_drop_count", drop_count, 0);
        reset = 1'b1;
        fb_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check("rq_idle_we", fb_we, 0);
        end
        check("rq_pix_final", pix_count, 0);

        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
